fetch_mem_bridge: RTL and testbench



---
 rtl/fetch_mem_bridge_pkg.sv | 37 +++
 rtl/fetch_mem_bridge_if.sv | 42 ++++
 rtl/fetch_mem_bridge_assembler.sv | 85 ++++++++
 rtl/fetch_mem_bridge.sv | 162 ++++++++++++++++
 tb/tb_fetch_mem_bridge.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_mem_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Packages : riscv_pkg, tortoise_pkg                                         |
// | Purpose  : Shared architectural constants, the exception record and the    |
// |            fetch_mem_bridge state encoding.                                |
// | Contents : XLEN, INSTR_PER_FETCH, exception_t, cause codes,                |
// |            fetch_bridge_state_e.                                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

package riscv_pkg;
  localparam int unsigned XLEN = 32;
endpackage : riscv_pkg

package tortoise_pkg;
  localparam int unsigned XLEN            = riscv_pkg::XLEN;
  localparam int unsigned INSTR_PER_FETCH = 2;

  // Exception causes reported with a fetched row.
  localparam logic [XLEN-1:0] INSTR_ADDR_MISALIGNED = XLEN'(0);
  localparam logic [XLEN-1:0] INSTR_ACCESS_FAULT    = XLEN'(1);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } fetch_bridge_state_e;
endpackage : tortoise_pkg

`default_nettype wire

// File: rtl/fetch_mem_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : fetch_mem_bridge_if                                            |
// | Purpose   : Bundles the fetch-stage handshake and the instruction-memory   |
// |             req/gnt/rvalid port served by fetch_mem_bridge.                |
// | Modports  : slave  - the bridge itself                                     |
// |             master - the environment (fetch stage plus memory)             |
// | Signals   : fetch_req_i, fetch_addr_i, fetch_ack_o, fetch_ex_o, instrs_o,  |
// |             mem_req_o, mem_addr_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i,   |
// |             mem_err_i (suffixes are as seen from the bridge)               |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface fetch_mem_bridge_if #(
  parameter int unsigned INSTR_PER_FETCH = tortoise_pkg::INSTR_PER_FETCH,
  parameter int unsigned ADDR_WIDTH      = riscv_pkg::XLEN
);
  // Fetch-stage side
  logic                              fetch_req_i;
  logic [ADDR_WIDTH-1:0]             fetch_addr_i;
  logic                              fetch_ack_o;
  tortoise_pkg::exception_t          fetch_ex_o;
  logic [INSTR_PER_FETCH-1:0][31:0]  instrs_o;
  // Instruction-memory side
  logic                              mem_req_o;
  logic [ADDR_WIDTH-1:0]             mem_addr_o;
  logic                              mem_gnt_i;
  logic                              mem_rvalid_i;
  logic [31:0]                       mem_rdata_i;
  logic                              mem_err_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output fetch_ack_o, fetch_ex_o, instrs_o, mem_req_o, mem_addr_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  fetch_ack_o, fetch_ex_o, instrs_o, mem_req_o, mem_addr_o
  );
endinterface : fetch_mem_bridge_if

`default_nettype wire

// File: rtl/fetch_mem_bridge_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_row_assembler                                             |
// | Purpose  : Holds the instruction row being built, the word counter k and   |
// |            the exception captured for the row.                             |
// | Ports    : clk_i, rst_i       clock / async active-high reset              |
// |            start_i            new memory fetch: k=0, row and ex cleared    |
// |            misalign_i/_addr_i misaligned request: ex set, row cleared      |
// |            wr_i, rdata_i      store a returned word into slot k            |
// |            err_i, fault_addr_i bus error on the stored word                |
// |            last_o             slot k is the final slot of the row          |
// |            instrs_o, ex_o     assembled row and its exception              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_row_assembler
  import tortoise_pkg::*;
#(
  parameter int unsigned INSTR_PER_FETCH = tortoise_pkg::INSTR_PER_FETCH,
  parameter int unsigned ADDR_WIDTH      = riscv_pkg::XLEN
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             misalign_i,
  input  logic [ADDR_WIDTH-1:0]            misalign_addr_i,
  input  logic                             wr_i,
  input  logic [31:0]                      rdata_i,
  input  logic                             err_i,
  input  logic [ADDR_WIDTH-1:0]            fault_addr_i,
  output logic                             last_o,
  output logic [INSTR_PER_FETCH-1:0][31:0] instrs_o,
  output exception_t                       ex_o
);
  localparam int unsigned KW = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;

  logic [KW-1:0] r_k;
  exception_t    r_ex;

  assign last_o = (r_k == KW'(INSTR_PER_FETCH - 1));
  assign ex_o   = r_ex;

  // Word counter: restarts on every new fetch, advances on each clean word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_k <= '0;
    end else if (start_i) begin
      r_k <= '0;
    end else if (wr_i && !err_i && !last_o) begin
      r_k <= r_k + KW'(1);
    end
  end

  // Only the first error of a fetch is recorded; the fetch ends on it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex <= '0;
    end else if (start_i) begin
      r_ex <= '0;
    end else if (misalign_i) begin
      r_ex.valid <= 1'b1;
      r_ex.cause <= INSTR_ADDR_MISALIGNED;
      r_ex.tval  <= XLEN'(misalign_addr_i);
    end else if (wr_i && err_i && !r_ex.valid) begin
      r_ex.valid <= 1'b1;
      r_ex.cause <= INSTR_ACCESS_FAULT;
      r_ex.tval  <= XLEN'(fault_addr_i);
    end
  end

  // Slots are zeroed when a fetch starts, so the slots after a faulting word
  // simply keep their cleared value.
  for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_slot
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        instrs_o[i] <= '0;
      end else if (start_i || misalign_i) begin
        instrs_o[i] <= '0;
      end else if (wr_i && (r_k == KW'(i))) begin
        instrs_o[i] <= rdata_i;
      end
    end
  end
endmodule : fetch_row_assembler

`default_nettype wire

// File: rtl/fetch_mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_mem_bridge                                                |
// | Purpose  : Serves fetch-stage row requests by reading INSTR_PER_FETCH      |
// |            sequential words from instruction memory, then acking the      |
// |            assembled row with its exception information.                   |
// | Ports    : clk_i    clock (rising edge)                                    |
// |            rst_i    asynchronous active-high reset                         |
// |            flush_i  abandon the current fetch                              |
// |            bus      fetch_mem_bridge_if.slave (fetch + memory signals)     |
// | Options  : FETCH_BRIDGE_ROW_REUSE_EN - when defined, the last error-free   |
// |            row is tagged with its address and a repeat request for that    |
// |            address is acked without memory traffic.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_mem_bridge
  import tortoise_pkg::*;
#(
  parameter int unsigned INSTR_PER_FETCH = tortoise_pkg::INSTR_PER_FETCH,
  parameter int unsigned ADDR_WIDTH      = riscv_pkg::XLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  fetch_mem_bridge_if.slave bus
);
  fetch_bridge_state_e             r_state;
  logic                            r_kill;
  logic                            r_mem_req;
  logic [ADDR_WIDTH-1:0]           r_mem_addr;

  logic                            w_accept;
  logic                            w_misaligned;
  logic                            w_reuse_hit;
  logic                            w_start;
  logic                            w_mis;
  logic                            w_rsp;
  logic                            w_discard;
  logic                            w_store;
  logic                            w_last;
  logic [INSTR_PER_FETCH-1:0][31:0] w_instrs;
  exception_t                      w_ex;

  assign w_accept     = (r_state == IDLE) && bus.fetch_req_i && !flush_i;
  assign w_misaligned = (bus.fetch_addr_i[1:0] != 2'b00);
  assign w_start      = w_accept && !w_misaligned && !w_reuse_hit;
  assign w_mis        = w_accept && w_misaligned;
  assign w_rsp        = (r_state == WAIT) && bus.mem_rvalid_i;
  // A flush seen earlier (kill) or now turns the pending response into a drain.
  assign w_discard    = r_kill || flush_i;
  assign w_store      = w_rsp && !w_discard;

`ifdef FETCH_BRIDGE_ROW_REUSE_EN
  logic                  r_tag_valid;
  logic [ADDR_WIDTH-1:0] r_tag;

  assign w_reuse_hit = r_tag_valid && (bus.fetch_addr_i == r_tag);

  // The tag names the row currently held in the assembler; any new fetch
  // overwrites that row, so it invalidates the tag until a clean completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_valid <= 1'b0;
      r_tag       <= '0;
    end else if (flush_i) begin
      r_tag_valid <= 1'b0;
    end else if (w_start) begin
      r_tag_valid <= 1'b0;
      r_tag       <= bus.fetch_addr_i;
    end else if (w_mis) begin
      r_tag_valid <= 1'b0;
    end else if (w_store && !bus.mem_err_i && w_last) begin
      r_tag_valid <= 1'b1;
    end
  end
`else
  assign w_reuse_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_kill     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_misaligned || w_reuse_hit) begin
              r_state <= ACK;
            end else begin
              r_state    <= REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {bus.fetch_addr_i[ADDR_WIDTH-1:2], 2'b00};
              r_kill     <= 1'b0;
            end
          end
        end
        REQ: begin
          // The request cannot be withdrawn once raised; remember the flush.
          if (flush_i) begin
            r_kill <= 1'b1;
          end
          if (bus.mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (w_discard) begin
              r_state <= IDLE;
              r_kill  <= 1'b0;
            end else if (bus.mem_err_i || w_last) begin
              r_state <= ACK;
            end else begin
              r_state    <= REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
            end
          end else if (flush_i) begin
            r_kill <= 1'b1;
          end
        end
        ACK: begin
          if (bus.fetch_req_i || flush_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_mem_addr is base + 4*k while a word is in flight, so it is the fault address.
  fetch_row_assembler #(
    .INSTR_PER_FETCH (INSTR_PER_FETCH),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_assembler (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (w_start),
    .misalign_i      (w_mis),
    .misalign_addr_i (bus.fetch_addr_i),
    .wr_i            (w_store),
    .rdata_i         (bus.mem_rdata_i),
    .err_i           (bus.mem_err_i),
    .fault_addr_i    (r_mem_addr),
    .last_o          (w_last),
    .instrs_o        (w_instrs),
    .ex_o            (w_ex)
  );

  assign bus.fetch_ack_o = (r_state == ACK) && !flush_i;
  assign bus.fetch_ex_o  = w_ex;
  assign bus.instrs_o    = w_instrs;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_addr_o  = r_mem_addr;
endmodule : fetch_mem_bridge

`default_nettype wire

// File: tb/tb_fetch_mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_mem_bridge                                             |
// | Purpose  : Self-checking bench for fetch_mem_bridge: directed scenarios    |
// |            followed by randomized fetches against a row-level model.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fetch_mem_bridge;
  localparam int NI = 2;
`ifdef FETCH_BRIDGE_ROW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;

  int tests = 0;
  int fails = 0;

  // Memory responder controls and log of granted word addresses.
  int          gnt_delay = 0;
  bit          err_en    = 1'b0;
  logic [31:0] err_addr  = '0;
  bit          spur      = 1'b0;
  logic [31:0] mem_log[$];

  // Model of the reusable row tag.
  bit          m_tag_valid = 1'b0;
  logic [31:0] m_tag       = '0;

  fetch_mem_bridge_if #(.INSTR_PER_FETCH(NI), .ADDR_WIDTH(32)) bus ();

  fetch_mem_bridge #(.INSTR_PER_FETCH(NI), .ADDR_WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0013;
    if (a == 32'h8000_0004) return 32'h0000_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h0F1E_2D3C;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: grant after gnt_delay request cycles, data one cycle after grant.
  bit          r_req_seen = 1'b0;
  bit          r_gnt_q    = 1'b0;
  logic [31:0] r_addr_seen = '0;
  int          r_wait_cnt = 0;
  initial begin : responder
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_err_i    = 1'b0;
    forever begin
      @(negedge clk);
      if (r_gnt_q && r_req_seen) begin
        mem_log.push_back(r_addr_seen);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = word_of(r_addr_seen);
        bus.mem_err_i    = err_en && (r_addr_seen == err_addr);
      end else if (spur) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = $urandom();
        bus.mem_err_i    = 1'b1;
        spur             = 1'b0;
      end else begin
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        bus.mem_err_i    = 1'b0;
      end
      r_req_seen  = bus.mem_req_o;
      r_addr_seen = bus.mem_addr_o;
      if (r_req_seen) begin
        r_gnt_q = (r_wait_cnt >= gnt_delay);
        r_wait_cnt++;
      end else begin
        r_gnt_q    = 1'b0;
        r_wait_cnt = 0;
      end
      bus.mem_gnt_i = r_gnt_q;
    end
  end

  // mode 0: plain transfer, 1: ack held with req low for 'hold' cycles,
  // 2: flush while the ack is pending.
  task automatic do_fetch(input logic [31:0] a, input int d, input bit inj, input int eidx,
                          input int mode, input int hold);
    logic [NI*32-1:0] ei;
    logic [64:0]      ee;
    logic [31:0]      ea[$];
    int               nw, lat, cyc;
    bit               hit;
    hit = REUSE && m_tag_valid && (a == m_tag);
    ei  = '0;
    ee  = '0;
    ea  = {};
    if (a[1:0] != 2'b00) begin
      ee          = {1'b1, 32'd0, a};
      lat         = 1;
      m_tag_valid = 1'b0;
    end else if (hit) begin
      for (int i = 0; i < NI; i++) ei[i*32 +: 32] = word_of(a + 32'(4 * i));
      lat = 1;
    end else begin
      nw = inj ? eidx + 1 : NI;
      for (int i = 0; i < nw; i++) begin
        ei[i*32 +: 32] = word_of(a + 32'(4 * i));
        ea.push_back(a + 32'(4 * i));
      end
      if (inj) ee = {1'b1, 32'd1, a + 32'(4 * eidx)};
      lat         = 1 + nw * (d + 2);
      m_tag_valid = !inj;
      m_tag       = a;
    end

    gnt_delay = d;
    err_en    = inj;
    err_addr  = a + 32'(4 * eidx);
    mem_log.delete();
    bus.fetch_addr_i = a;
    bus.fetch_req_i  = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.fetch_ack_o && cyc < 200);
    chk("ack_latency", 128'(cyc), 128'(lat));
    chk("instrs", 128'(bus.instrs_o), 128'(ei));
    chk("exception", 128'(bus.fetch_ex_o), 128'(ee));
    chk("mem_read_count", 128'(mem_log.size()), 128'(ea.size()));
    for (int i = 0; i < ea.size() && i < mem_log.size(); i++)
      chk("mem_addr", 128'(mem_log[i]), 128'(ea[i]));

    if (mode == 1) begin
      bus.fetch_req_i = 1'b0;
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("ack_held", 128'(bus.fetch_ack_o), 128'(1));
        chk("instrs_stable", 128'(bus.instrs_o), 128'(ei));
      end
      bus.fetch_req_i = 1'b1;
      tick();
      bus.fetch_req_i = 1'b0;
      chk("single_transfer", 128'(bus.fetch_ack_o), 128'(0));
    end else if (mode == 2) begin
      flush = 1'b1;
      #1;
      chk("ack_masked_by_flush", 128'(bus.fetch_ack_o), 128'(0));
      tick();
      flush           = 1'b0;
      bus.fetch_req_i = 1'b0;
      m_tag_valid     = 1'b0;
      chk("idle_after_flush", 128'(bus.fetch_ack_o), 128'(0));
    end else begin
      tick();
      bus.fetch_req_i = 1'b0;
      chk("single_transfer", 128'(bus.fetch_ack_o), 128'(0));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] a, prev_a;
    int          cyc;
    rst              = 1'b1;
    flush            = 1'b0;
    bus.fetch_req_i  = 1'b0;
    bus.fetch_addr_i = '0;
    tick();
    chk("rst_ack", 128'(bus.fetch_ack_o), 128'(0));
    chk("rst_mem_req", 128'(bus.mem_req_o), 128'(0));
    chk("rst_mem_addr", 128'(bus.mem_addr_o), 128'(0));
    chk("rst_instrs", 128'(bus.instrs_o), 128'(0));
    chk("rst_ex", 128'(bus.fetch_ex_o), 128'(0));
    rst = 1'b0;
    tick();

    // Basic row, then an immediate repeat of the same address.
    do_fetch(32'h8000_0000, 0, 1'b0, 0, 0, 0);
    do_fetch(32'h8000_0000, 0, 1'b0, 0, 0, 0);
    // Flush in IDLE: no visible effect besides dropping any reusable row.
    flush = 1'b1;
    tick();
    flush       = 1'b0;
    m_tag_valid = 1'b0;
    chk("idle_flush_ack", 128'(bus.fetch_ack_o), 128'(0));
    chk("idle_flush_req", 128'(bus.mem_req_o), 128'(0));
    do_fetch(32'h8000_0000, 0, 1'b0, 0, 0, 0);

    // Misaligned, bus error on word 1, error on word 0 across the address wrap.
    do_fetch(32'h8000_0002, 0, 1'b0, 0, 0, 0);
    do_fetch(32'h0000_0100, 0, 1'b1, 1, 0, 0);
    do_fetch(32'hFFFF_FFFC, 1, 1'b1, 0, 0, 0);
    do_fetch(32'hFFFF_FFFC, 0, 1'b0, 0, 0, 0);

    // Flush during REQ with a slow grant: request held, read drained, no ack.
    gnt_delay = 3;
    err_en    = 1'b0;
    mem_log.delete();
    bus.fetch_addr_i = 32'h0000_0200;
    bus.fetch_req_i  = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.mem_req_o && cyc < 20);
    flush           = 1'b1;
    bus.fetch_req_i = 1'b0;
    tick();
    flush       = 1'b0;
    m_tag_valid = 1'b0;
    cyc = 0;
    while (mem_log.size() == 0 && cyc < 20) begin
      chk("req_held_until_gnt", 128'(bus.mem_req_o), 128'(1));
      tick();
      cyc++;
    end
    chk("flushed_read_granted", 128'(mem_log.size()), 128'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_ack_after_flush", 128'(bus.fetch_ack_o), 128'(0));
    end
    chk("drained_idle", 128'(bus.mem_req_o), 128'(0));
    do_fetch(32'h0000_0400, 0, 1'b0, 0, 0, 0);

    // Ack held with fetch_req_i low, then flush while acking.
    do_fetch(32'h0000_0800, 0, 1'b0, 0, 1, 4);
    do_fetch(32'h0000_0C00, 2, 1'b0, 0, 2, 0);

    // Stray rvalid while idle must be ignored.
    spur = 1'b1;
    tick();
    tick();
    chk("spurious_ack", 128'(bus.fetch_ack_o), 128'(0));
    chk("spurious_req", 128'(bus.mem_req_o), 128'(0));
    do_fetch(32'h0000_1000, 0, 1'b0, 0, 0, 0);

    // Reset in the middle of a fetch, with a read outstanding.
    gnt_delay = 0;
    err_en    = 1'b0;
    bus.fetch_addr_i = 32'h0000_0300;
    bus.fetch_req_i  = 1'b1;
    tick();
    tick();
    tick();
    rst             = 1'b1;
    bus.fetch_req_i = 1'b0;
    #1;
    chk("midrst_req", 128'(bus.mem_req_o), 128'(0));
    chk("midrst_addr", 128'(bus.mem_addr_o), 128'(0));
    chk("midrst_instrs", 128'(bus.instrs_o), 128'(0));
    chk("midrst_ex", 128'(bus.fetch_ex_o), 128'(0));
    tick();
    rst         = 1'b0;
    m_tag_valid = 1'b0;
    do_fetch(32'h0000_0300, 0, 1'b0, 0, 0, 0);

    // Randomized fetches.
    prev_a = 32'h0000_0300;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) a = prev_a;
      else                           a = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      do_fetch(a, int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0),
               int'($urandom_range(0, NI - 1)), int'($urandom_range(0, 2)),
               int'($urandom_range(1, 3)));
      prev_a = a;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule : tb_fetch_mem_bridge

`default_nettype wire
